axis_video_to_dvp: RTL and testbench



---
 rtl/axis_video_to_dvp.sv | 218 +++++++++++++++++++++
 tb/tb_axis_video_to_dvp.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_video_to_dvp.sv
// AXI4-Stream RGB888 to 8-bit DVP RGB565 camera emulator.
// All DVP outputs and busy are registered one cycle behind the FSM.
module axis_video_to_dvp #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int VSYNC_W  = 3,
  parameter int V_BP     = 16,
  parameter int V_FP     = 16,
  parameter int CNT_W    = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        en,
  input  logic        clr_err,
  input  logic [23:0] s_axis_video_tdata,
  input  logic        s_axis_video_tvalid,
  output logic        s_axis_video_tready,
  input  logic        s_axis_video_tuser,
  input  logic        s_axis_video_tlast,
  output logic [7:0]  dvp_data,
  output logic        dvp_href,
  output logic        dvp_vsync,
  output logic        underflow,
  output logic        len_err,
  output logic        busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBP    = 3'd2;
  localparam logic [2:0] S_LINE   = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  localparam logic [2:0] S_VFP    = 3'd5;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(VSYNC_W - 1);
  localparam logic [CNT_W-1:0] BP_LAST   = CNT_W'((V_BP > 0) ? V_BP - 1 : 0);
  localparam logic [CNT_W-1:0] FP_LAST   = CNT_W'((V_FP > 0) ? V_FP - 1 : 0);
  localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(V_ACTIVE - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pix;
  logic [CNT_W-1:0] line;
  logic             phase;
  logic             pad;
  logic             drop;
  logic             nochk;
  logic [7:0]       lo_byte;
  logic             tready_c;
  logic             hs;
  logic             pix_hs;
  logic             tlast_hs;
  logic             early;
  logic             missing;
  logic             sof_err;
  logic             uf_set;
  logic             len_set;
  logic             unused_bits;

  always_comb begin
    tready_c = 1'b0;
    case (state)
      S_IDLE:   tready_c = en && !(s_axis_video_tvalid && s_axis_video_tuser);
      S_LINE:   tready_c = !phase && !pad;
      S_HBLANK: tready_c = drop;
      S_VFP:    tready_c = drop;
      default:  tready_c = 1'b0;
    endcase
  end

  assign s_axis_video_tready = aresetn && tready_c;
  assign hs       = s_axis_video_tvalid && s_axis_video_tready;
  assign pix_hs   = hs && (state == S_LINE);
  assign tlast_hs = hs && s_axis_video_tlast;

  // nochk: line started while a missing-EOL drop was still pending
  assign early   = pix_hs && !nochk && s_axis_video_tlast && (pix != PIX_LAST);
  assign missing = pix_hs && !nochk && !s_axis_video_tlast && (pix == PIX_LAST);
  assign sof_err = pix_hs && !nochk && s_axis_video_tuser &&
                   ((pix != '0) || (line != '0));
  assign uf_set  = (state == S_LINE) && !phase && !pad && !s_axis_video_tvalid;
  assign len_set = early || missing || sof_err;

  assign unused_bits = ^{s_axis_video_tdata[18:16],
                         s_axis_video_tdata[10:8],
                         s_axis_video_tdata[1:0]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pix       <= '0;
      line      <= '0;
      phase     <= 1'b0;
      pad       <= 1'b0;
      drop      <= 1'b0;
      nochk     <= 1'b0;
      lo_byte   <= '0;
      dvp_data  <= '0;
      dvp_href  <= 1'b0;
      dvp_vsync <= 1'b0;
      busy      <= 1'b0;
    end else begin
      dvp_data  <= '0;
      dvp_href  <= 1'b0;
      dvp_vsync <= 1'b0;
      busy      <= (state != S_IDLE);
      case (state)
        S_IDLE: begin
          cnt   <= '0;
          pix   <= '0;
          line  <= '0;
          phase <= 1'b0;
          pad   <= 1'b0;
          drop  <= 1'b0;
          nochk <= 1'b0;
          if (en && s_axis_video_tvalid && s_axis_video_tuser)
            state <= S_VSYNC;
        end
        S_VSYNC: begin
          dvp_vsync <= 1'b1;
          if (cnt == VS_LAST) begin
            cnt   <= '0;
            state <= (V_BP > 0) ? S_VBP : S_LINE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_VBP: begin
          if (cnt == BP_LAST) begin
            cnt   <= '0;
            state <= S_LINE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_LINE: begin
          dvp_href <= 1'b1;
          phase    <= !phase;
          if (!phase) begin
            if (pix_hs) begin
              dvp_data <= {s_axis_video_tdata[23:19], s_axis_video_tdata[7:5]};
              lo_byte  <= {s_axis_video_tdata[4:2], s_axis_video_tdata[15:11]};
            end else begin
              lo_byte  <= '0;
            end
            if (early)
              pad <= 1'b1;
            if (missing)
              drop <= 1'b1;
          end else begin
            dvp_data <= lo_byte;
            if (pix == PIX_LAST) begin
              pix   <= '0;
              pad   <= 1'b0;
              nochk <= 1'b0;
              cnt   <= '0;
              state <= S_HBLANK;
            end else begin
              pix <= pix + ONE;
            end
          end
        end
        S_HBLANK: begin
          if (tlast_hs)
            drop <= 1'b0;
          if (cnt == HB_LAST) begin
            cnt <= '0;
            if (line == LINE_LAST) begin
              line  <= '0;
              state <= (V_FP > 0) ? S_VFP : S_IDLE;
            end else begin
              line  <= line + ONE;
              nochk <= drop && !tlast_hs;
              drop  <= 1'b0;
              state <= S_LINE;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_VFP: begin
          if (tlast_hs)
            drop <= 1'b0;
          if (cnt == FP_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // a set event in the same cycle as clr_err keeps the flag
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      underflow <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      if (uf_set)
        underflow <= 1'b1;
      else if (clr_err)
        underflow <= 1'b0;
      if (len_set)
        len_err <= 1'b1;
      else if (clr_err)
        len_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_video_to_dvp.sv
// Directed bench for axis_video_to_dvp with a byte scoreboard.
// Frame timing is measured from the DVP pins by a negedge monitor.
module tb_axis_video_to_dvp;

  localparam int HA = 4;
  localparam int VA = 2;
  localparam int HB = 3;
  localparam int VW = 2;
  localparam int BP = 2;
  localparam int FP = 2;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        en = 1'b0;
  logic        clr_err = 1'b0;
  logic [23:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        tuser = 1'b0;
  logic        tlast = 1'b0;
  logic [7:0]  dvp_data;
  logic        dvp_href;
  logic        dvp_vsync;
  logic        underflow;
  logic        len_err;
  logic        busy;

  always #5 clk = ~clk;

  axis_video_to_dvp #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_W(VW), .V_BP(BP), .V_FP(FP), .CNT_W(16)
  ) dut (
    .aclk(clk),
    .aresetn(aresetn),
    .en(en),
    .clr_err(clr_err),
    .s_axis_video_tdata(tdata),
    .s_axis_video_tvalid(tvalid),
    .s_axis_video_tready(tready),
    .s_axis_video_tuser(tuser),
    .s_axis_video_tlast(tlast),
    .dvp_data(dvp_data),
    .dvp_href(dvp_href),
    .dvp_vsync(dvp_vsync),
    .underflow(underflow),
    .len_err(len_err),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic [7:0] exp_b;

  int cyc = 0;
  int frames = 0;
  int vs_len = 0;
  int href_cnt = 0;
  int lines = 0;
  int gap_bp = -1;
  int gap_hb = -1;
  int tail = -1;
  int t_vf = 0;
  int t_hf = 0;
  logic pv = 1'b0;
  logic ph = 1'b0;
  logic pb = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops on href, timing stats per frame
  always @(negedge clk) begin
    cyc++;
    if (dvp_vsync && !pv) begin
      frames++;
      vs_len = 0;
      href_cnt = 0;
      lines = 0;
      gap_bp = -1;
      gap_hb = -1;
      tail = -1;
    end
    if (dvp_vsync)
      vs_len++;
    if (!dvp_vsync && pv)
      t_vf = cyc;
    if (dvp_href && !ph) begin
      if (lines == 0)
        gap_bp = cyc - t_vf;
      else
        gap_hb = cyc - t_hf;
      lines++;
    end
    if (dvp_href) begin
      href_cnt++;
      exp_b = (q.size() > 0) ? q.pop_front() : 8'hxx;
      chk("dvp_byte", {24'd0, dvp_data}, {24'd0, exp_b});
    end
    if (!dvp_href && ph)
      t_hf = cyc;
    if (!busy && pb)
      tail = cyc - t_hf;
    pv = dvp_vsync;
    ph = dvp_href;
    pb = busy;
  end

  task automatic send(input logic [23:0] d, input logic u, input logic l,
                      input bit exp, output int waited);
    bit hs;
    hs = 1'b0;
    waited = 0;
    @(negedge clk);
    tdata = d;
    tuser = u;
    tlast = l;
    tvalid = 1'b1;
    if (exp) begin
      q.push_back({d[23:19], d[7:5]});
      q.push_back({d[4:2], d[15:11]});
    end
    for (int i = 0; i < 100 && !hs; i++) begin
      #4;
      hs = tready;
      @(posedge clk);
      waited = i + 1;
      if (!hs)
        @(negedge clk);
    end
    chk("send_hs", {31'd0, hs}, 32'd1);
  endtask

  task automatic beat(input logic [23:0] d, input logic u, input logic l);
    int w;
    send(d, u, l, 1'b1, w);
  endtask

  task automatic frame(input logic [23:0] p0);
    for (int i = 0; i < 8; i++)
      beat((i == 0) ? p0 : 24'($urandom), (i == 0), (i == 3 || i == 7));
  endtask

  task automatic finish_frame(input string tag);
    bit done;
    done = 1'b0;
    @(negedge clk);
    tvalid = 1'b0;
    tuser = 1'b0;
    tlast = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = !busy;
    end
    chk({tag, "_idle"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    #1;
    chk({tag, "_vsync_len"}, vs_len, VW);
    chk({tag, "_vbp_gap"}, gap_bp, BP);
    chk({tag, "_hblank_gap"}, gap_hb, HB);
    chk({tag, "_href_cycles"}, href_cnt, 2 * HA * VA);
    chk({tag, "_lines"}, lines, VA);
    chk({tag, "_busy_tail"}, tail, HB + FP);
    chk({tag, "_queue_empty"}, q.size(), 0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, {24'd0, dvp_data}, 32'd0);
    chk({tag, "_href"}, {31'd0, dvp_href}, 32'd0);
    chk({tag, "_vsync"}, {31'd0, dvp_vsync}, 32'd0);
    chk({tag, "_tready"}, {31'd0, tready}, 32'd0);
    chk({tag, "_underflow"}, {31'd0, underflow}, 32'd0);
    chk({tag, "_len_err"}, {31'd0, len_err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int w;
    int f0;
    bit any_rdy;
    bit fell;
    bit seen;

    // reset state, with en and an SOF already presented
    en = 1'b1;
    tvalid = 1'b1;
    tuser = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    tvalid = 1'b0;
    tuser = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;

    // 1: nominal frame
    frame(24'hF800FC);
    finish_frame("nominal");
    chk("nominal_underflow", {31'd0, underflow}, 32'd0);
    chk("nominal_len_err", {31'd0, len_err}, 32'd0);

    // 2: pre-SOF garbage is dropped in IDLE
    f0 = frames;
    for (int i = 0; i < 5; i++) begin
      send(24'($urandom), 1'b0, (i == 4), 1'b0, w);
      chk("garbage_accept_wait", w, 1);
    end
    chk("garbage_no_vsync", frames, f0);
    frame(24'hF800FC);
    finish_frame("garbage");
    chk("garbage_len_err", {31'd0, len_err}, 32'd0);

    // 3: underflow on pixel 2 of line 0, set collides with clr_err
    beat(24'h123456, 1'b1, 1'b0);
    beat(24'hA5C3E7, 1'b0, 1'b0);
    @(negedge clk);
    tvalid = 1'b0;
    clr_err = 1'b1;
    q.push_back(8'h00);
    q.push_back(8'h00);
    @(negedge clk);
    @(negedge clk);
    clr_err = 1'b0;
    beat(24'h0FF0F0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      beat(24'($urandom), 1'b0, (i == 3));
    finish_frame("underflow");
    chk("underflow_flag", {31'd0, underflow}, 32'd1);
    chk("underflow_len_err", {31'd0, len_err}, 32'd0);
    pulse_clr();
    chk("underflow_cleared", {31'd0, underflow}, 32'd0);

    // 4: early EOL on pixel 1 of line 0
    beat(24'h80FF01, 1'b1, 1'b0);
    beat(24'h3C5A96, 1'b0, 1'b1);
    repeat (4) q.push_back(8'h00);
    send(24'hFFFFFF, 1'b0, 1'b0, 1'b1, w);
    chk("early_pad_wait", w, 9);
    beat(24'h010203, 1'b0, 1'b0);
    beat(24'h7F7F7F, 1'b0, 1'b0);
    beat(24'hC0FFEE, 1'b0, 1'b1);
    finish_frame("early_eol");
    chk("early_len_err", {31'd0, len_err}, 32'd1);
    chk("early_underflow", {31'd0, underflow}, 32'd0);
    pulse_clr();
    chk("early_cleared", {31'd0, len_err}, 32'd0);

    // 5: missing EOL, beats 5-6 dropped in HBLANK
    beat(24'h112233, 1'b1, 1'b0);
    beat(24'h445566, 1'b0, 1'b0);
    beat(24'h778899, 1'b0, 1'b0);
    beat(24'hAABBCC, 1'b0, 1'b0);
    send(24'hDEAD00, 1'b0, 1'b0, 1'b0, w);
    chk("missing_drop_wait", w, 2);
    send(24'hBEEF00, 1'b0, 1'b1, 1'b0, w);
    chk("missing_drop_last_wait", w, 1);
    send(24'h13579B, 1'b0, 1'b0, 1'b1, w);
    chk("missing_line1_wait", w, 2);
    beat(24'h2468AC, 1'b0, 1'b0);
    beat(24'hFEDCBA, 1'b0, 1'b0);
    beat(24'h0A0B0C, 1'b0, 1'b1);
    finish_frame("missing_eol");
    chk("missing_len_err", {31'd0, len_err}, 32'd1);
    pulse_clr();

    // 6a: asynchronous reset in line 1
    for (int i = 0; i < 6; i++)
      beat(24'($urandom), (i == 0), (i == 3));
    @(negedge clk);
    #2;
    aresetn = 1'b0;
    tvalid = 1'b0;
    tuser = 1'b0;
    tlast = 1'b0;
    #1;
    check_reset_outputs("midreset");
    q.delete();
    @(negedge clk);
    aresetn = 1'b1;
    frame(24'h00FF00);
    finish_frame("after_reset");
    chk("after_reset_len_err", {31'd0, len_err}, 32'd0);

    // 6b: en dropped during VBP, frame still completes
    fell = 1'b0;
    seen = 1'b0;
    fork
      frame(24'hFFFFFF);
      begin
        for (int i = 0; i < 60 && !fell; i++) begin
          @(negedge clk);
          if (dvp_vsync)
            seen = 1'b1;
          else if (seen)
            fell = 1'b1;
        end
        en = 1'b0;
      end
    join
    chk("en_vbp_reached", {31'd0, fell}, 32'd1);
    finish_frame("en_drop");
    f0 = frames;
    any_rdy = 1'b0;
    @(negedge clk);
    tvalid = 1'b1;
    tuser = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (tready)
        any_rdy = 1'b1;
      @(negedge clk);
    end
    tvalid = 1'b0;
    tuser = 1'b0;
    chk("en_off_tready", {31'd0, any_rdy}, 32'd0);
    chk("en_off_no_frame", frames, f0);
    chk("en_off_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
